// File: rtl/sram_1rw_sched_pkg.sv
// Shared types for the single-port SRAM scheduler: FSM states, requester id,
// and the request record presented by each requester.
package sram_sched_pkg;

  localparam int unsigned MAX_ADDR_W = 16;
  localparam int unsigned MAX_DATA_W = 128;

  typedef enum logic [1:0] {
    INIT,
    RUN,
    DRAIN
  } state_t;

  typedef logic req_id_t;

  typedef struct packed {
    logic                  write;
    logic [MAX_ADDR_W-1:0] addr;
    logic [MAX_DATA_W-1:0] wdata;
  } req_t;

  function automatic logic [1:0] id_onehot(input req_id_t id);
    return id ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/sram_1rw_sched_if.sv
// Two-requester valid/ready bus with a shared read-response return path.
interface sram_1rw_sched_if #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 64
);

  logic [1:0]             req_valid;
  logic [1:0]             req_ready;
  logic [1:0]             req_write;
  logic [1:0][ADDR_W-1:0] req_addr;
  logic [1:0][DATA_W-1:0] req_wdata;
  logic [1:0]             resp_valid;
  logic [DATA_W-1:0]      resp_data;

  modport master (
    output req_valid, req_write, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_data
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata,
    output req_ready, resp_valid, resp_data
  );

endinterface

// File: rtl/sram_1rw_sched_rr_arb2.sv
// Two-input round-robin arbiter; the pointer flips to the other requester
// after every grant and holds on idle cycles.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] valid,
  input  logic       advance,
  output logic [1:0] grant
);

  logic ptr;

  always_comb begin
    grant = '0;
    if (advance) begin
      if (valid == 2'b11) grant = ptr ? 2'b10 : 2'b01;
      else                grant = valid;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)         ptr <= 1'b0;
    else if (|grant) ptr <= grant[0];
  end

endmodule

// File: rtl/sram_1rw_sched.sv
// Scheduler for one 1RW SRAM macro: zero-fills the array after reset/clear,
// then shares the port between two requesters with round-robin arbitration.
module sram_1rw_sched
  import sram_sched_pkg::*;
#(
  parameter int unsigned ADDR_W = 9,
  parameter int unsigned DATA_W = 64,
  parameter int unsigned DEPTH  = 512
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              clear,
  output logic              init_done,
  sram_1rw_sched_if.slave   bus,
  output logic              mem_en,
  output logic              mem_wmode,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int unsigned CNT_W = ADDR_W + 1;

  state_t           state;
  logic [CNT_W-1:0] init_cnt;
  logic             rd_pend;
  req_id_t          rd_id;

  logic             run_ok;
  logic [1:0]       grant;
  req_id_t          gid;
  logic             sel_write;

  // Grants are suppressed in the clear cycle and while reset is held, so a
  // reset from RUN never leaks a ready pulse.
  assign run_ok = (state == RUN) && !clear && !reset;

  rr_arb2 u_arb (
    .clk     (clock),
    .rst     (reset),
    .valid   (bus.req_valid),
    .advance (run_ok),
    .grant   (grant)
  );

  assign gid           = grant[1];
  assign sel_write     = bus.req_write[gid];
  assign bus.req_ready = grant;

  always_comb begin
    mem_en    = 1'b0;
    mem_wmode = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (!reset) begin
      case (state)
        INIT: begin
          mem_en    = 1'b1;
          mem_wmode = 1'b1;
          mem_addr  = init_cnt[ADDR_W-1:0];
        end
        RUN: begin
          if (|grant) begin
            mem_en    = 1'b1;
            mem_wmode = sel_write;
            mem_addr  = bus.req_addr[gid];
            mem_wdata = bus.req_wdata[gid];
          end
        end
        default: ;
      endcase
    end
  end

  // A read lost to reset must not surface, hence the reset gate here too.
  assign bus.resp_valid = (rd_pend && !reset) ? id_onehot(rd_id) : 2'b00;
  assign bus.resp_data  = mem_rdata;

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= INIT;
      init_cnt  <= '0;
      init_done <= 1'b0;
      rd_pend   <= 1'b0;
      rd_id     <= 1'b0;
    end else begin
      rd_pend <= (|grant) && !sel_write;
      rd_id   <= gid;
      case (state)
        INIT: begin
          if (clear) begin
            init_cnt <= '0;
          end else if (init_cnt == CNT_W'(DEPTH - 1)) begin
            state     <= RUN;
            init_done <= 1'b1;
            init_cnt  <= '0;
          end else begin
            init_cnt <= init_cnt + CNT_W'(1);
          end
        end
        RUN: begin
          if (clear) begin
            state     <= DRAIN;
            init_done <= 1'b0;
          end
        end
        DRAIN: begin
          state    <= INIT;
          init_cnt <= '0;
        end
        default: state <= INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_1rw_sched.sv
// Self-checking bench for sram_1rw_sched: behavioural 1RW macro, shadow memory,
// round-robin reference model and a read-response scoreboard.
module tb_sram_1rw_sched;

  localparam int unsigned ADDR_W = 9;
  localparam int unsigned DATA_W = 64;
  localparam int unsigned DEPTH  = 512;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              clear = 1'b0;
  logic              init_done;
  logic              mem_en;
  logic              mem_wmode;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  sram_1rw_sched_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  sram_1rw_sched #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clock     (clock),
    .reset     (reset),
    .clear     (clear),
    .init_done (init_done),
    .bus       (bus),
    .mem_en    (mem_en),
    .mem_wmode (mem_wmode),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  always #5 clock = ~clock;

  // Behavioural macro: synchronous write, registered read data.
  logic [DATA_W-1:0] macro_mem [DEPTH];
  always @(posedge clock) begin
    if (mem_en) begin
      if (mem_wmode) macro_mem[mem_addr] <= mem_wdata;
      else           mem_rdata <= macro_mem[mem_addr];
    end
  end

  typedef struct {
    logic              id;
    logic [DATA_W-1:0] data;
    int unsigned       due;
  } exp_t;

  exp_t              sb[$];
  logic [DATA_W-1:0] shadow [DEPTH];
  int unsigned       cyc = 0;
  int                vectors = 0;
  int                miscompares = 0;
  logic              exp_ptr = 1'b0;
  logic              model_run = 1'b0;

  logic [1:0]        exp_g;
  logic [1:0]        obs_ready;
  logic              obs_en, obs_wm, obs_done;
  logic [ADDR_W-1:0] obs_addr;
  logic [DATA_W-1:0] obs_wd;

  always @(posedge clock) cyc <= cyc + 1;

  // Response scoreboard: each expected read is due exactly one cycle after its grant.
  always @(negedge clock) begin
    logic [1:0] erv;
    vectors++;
    if (sb.size() != 0 && sb[0].due == cyc) begin
      erv = sb[0].id ? 2'b10 : 2'b01;
      if (bus.resp_valid !== erv || bus.resp_data !== sb[0].data) begin
        miscompares++;
        $display("FAIL resp cyc=%0d: resp_valid=%b resp_data=%h, expected %b %h",
                 cyc, bus.resp_valid, bus.resp_data, erv, sb[0].data);
      end
      void'(sb.pop_front());
    end else if (bus.resp_valid !== 2'b00) begin
      miscompares++;
      $display("FAIL resp_idle cyc=%0d: resp_valid=%b, expected 00", cyc, bus.resp_valid);
    end
  end

  // Drives one cycle of stimulus, samples the DUT mid-cycle and advances the reference model.
  task automatic apply(input logic [1:0] v, input logic [1:0] w,
                       input logic [ADDR_W-1:0] a0, input logic [ADDR_W-1:0] a1,
                       input logic [DATA_W-1:0] d0, input logic [DATA_W-1:0] d1,
                       input logic clr);
    logic              g;
    logic [ADDR_W-1:0] ga;
    bus.req_valid    = v;
    bus.req_write    = w;
    bus.req_addr[0]  = a0;
    bus.req_addr[1]  = a1;
    bus.req_wdata[0] = d0;
    bus.req_wdata[1] = d1;
    clear            = clr;
    @(negedge clock);
    obs_ready = bus.req_ready;
    obs_en    = mem_en;
    obs_wm    = mem_wmode;
    obs_addr  = mem_addr;
    obs_wd    = mem_wdata;
    obs_done  = init_done;
    if (!model_run || clr || reset) exp_g = 2'b00;
    else if (v == 2'b11)            exp_g = exp_ptr ? 2'b10 : 2'b01;
    else                            exp_g = v;
    if (exp_g != 2'b00) begin
      g       = exp_g[1];
      ga      = g ? a1 : a0;
      exp_ptr = ~g;
      if (w[g]) shadow[ga] = g ? d1 : d0;
      else      sb.push_back('{id: g, data: shadow[ga], due: cyc + 1});
    end
    if (clr) model_run = 1'b0;
    @(posedge clock);
    #1;
  endtask

  task automatic test_init_sequence();
    for (int unsigned i = 0; i < DEPTH; i++) begin
      apply(2'b11, 2'b11, '0, '0, '1, '1, 1'b0);
      vectors++;
      if (obs_ready !== 2'b00 || obs_en !== 1'b1 || obs_wm !== 1'b1 ||
          obs_addr !== ADDR_W'(i) || obs_wd !== '0 || obs_done !== 1'b0) begin
        miscompares++;
        $display("FAIL init_write[%0d]: ready=%b en=%b wmode=%b addr=%0d wdata=%h init_done=%b, expected 00 1 1 %0d 0 0",
                 i, obs_ready, obs_en, obs_wm, obs_addr, obs_wd, obs_done, i);
      end
    end
    bus.req_valid = 2'b00;
    clear         = 1'b0;
    @(negedge clock);
    vectors++;
    if (init_done !== 1'b1) begin
      miscompares++;
      $display("FAIL init_done: init_done=%b, expected 1 after %0d init cycles", init_done, DEPTH);
    end
    @(posedge clock);
    #1;
    for (int unsigned i = 0; i < DEPTH; i++) shadow[i] = '0;
    model_run = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    apply(2'b11, 2'b11, 9'd3, 9'd4, 64'd1, 64'd2, 1'b0);
    vectors++;
    if (obs_ready !== 2'b00 || obs_en !== 1'b0 || obs_wm !== 1'b0 || obs_done !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_state: ready=%b en=%b wmode=%b init_done=%b, expected 00 0 0 0",
               obs_ready, obs_en, obs_wm, obs_done);
    end
    reset   = 1'b0;
    exp_ptr = 1'b0;
    test_init_sequence();
  endtask

  task automatic test_raw();
    apply(2'b01, 2'b01, 9'd5, 9'd0, 64'hDEAD_BEEF, 64'd0, 1'b0);
    vectors++;
    if (obs_ready !== 2'b01 || obs_ready !== exp_g || obs_en !== 1'b1 || obs_wm !== 1'b1 ||
        obs_addr !== 9'd5 || obs_wd !== 64'hDEAD_BEEF) begin
      miscompares++;
      $display("FAIL raw_write: ready=%b en=%b wmode=%b addr=%0d wdata=%h, expected 01 1 1 5 deadbeef",
               obs_ready, obs_en, obs_wm, obs_addr, obs_wd);
    end
    apply(2'b01, 2'b00, 9'd5, 9'd0, 64'd0, 64'd0, 1'b0);
    vectors++;
    if (obs_ready !== 2'b01 || obs_en !== 1'b1 || obs_wm !== 1'b0 || obs_addr !== 9'd5) begin
      miscompares++;
      $display("FAIL raw_read5: ready=%b en=%b wmode=%b addr=%0d, expected 01 1 0 5",
               obs_ready, obs_en, obs_wm, obs_addr);
    end
    apply(2'b01, 2'b00, 9'd6, 9'd0, 64'd0, 64'd0, 1'b0);
    vectors++;
    if (obs_ready !== 2'b01 || obs_en !== 1'b1 || obs_wm !== 1'b0 || obs_addr !== 9'd6) begin
      miscompares++;
      $display("FAIL raw_read6: ready=%b en=%b wmode=%b addr=%0d, expected 01 1 0 6",
               obs_ready, obs_en, obs_wm, obs_addr);
    end
    apply(2'b00, 2'b11, 9'd1, 9'd2, 64'd7, 64'd8, 1'b0);
    vectors++;
    if (obs_ready !== 2'b00 || obs_en !== 1'b0) begin
      miscompares++;
      $display("FAIL idle: ready=%b en=%b, expected 00 0", obs_ready, obs_en);
    end
  endtask

  task automatic test_contention();
    logic [ADDR_W-1:0] a0_tab [6] = '{9'd5, 9'd9, 9'd12, 9'd6, 9'd12, 9'd5};
    logic [ADDR_W-1:0] a1_tab [6] = '{9'd9, 9'd5, 9'd6, 9'd12, 9'd6, 9'd9};
    logic [1:0]        want;
    // Lead-in grant to requester 1 so the alternation starts at requester 0.
    apply(2'b10, 2'b00, 9'd0, 9'd6, 64'd0, 64'd0, 1'b0);
    vectors++;
    if (obs_ready !== 2'b10) begin
      miscompares++;
      $display("FAIL contention_leadin: ready=%b, expected 10", obs_ready);
    end
    for (int k = 0; k < 6; k++) begin
      apply(2'b11, (k == 3) ? 2'b10 : 2'b00, a0_tab[k], a1_tab[k],
            64'd0, 64'h0BAD_F00D_CAFE_0003, 1'b0);
      want = (k % 2 == 0) ? 2'b01 : 2'b10;
      vectors++;
      if (obs_ready !== want || obs_ready !== exp_g || obs_en !== 1'b1 ||
          obs_addr !== (want[1] ? a1_tab[k] : a0_tab[k])) begin
        miscompares++;
        $display("FAIL contention[%0d]: ready=%b en=%b addr=%0d, expected %b 1 %0d",
                 k, obs_ready, obs_en, obs_addr, want, want[1] ? a1_tab[k] : a0_tab[k]);
      end
    end
    apply(2'b00, 2'b00, '0, '0, '0, '0, 1'b0);
  endtask

  task automatic test_single();
    apply(2'b10, 2'b00, 9'd0, 9'd5, 64'd0, 64'd0, 1'b0);
    vectors++;
    if (obs_ready !== 2'b10 || obs_addr !== 9'd5) begin
      miscompares++;
      $display("FAIL single0: ready=%b addr=%0d, expected 10 5", obs_ready, obs_addr);
    end
    apply(2'b10, 2'b10, 9'd0, 9'd9, 64'd0, 64'h1234_5678_9ABC_DEF0, 1'b0);
    vectors++;
    if (obs_ready !== 2'b10 || obs_wm !== 1'b1 || obs_wd !== 64'h1234_5678_9ABC_DEF0) begin
      miscompares++;
      $display("FAIL single1: ready=%b wmode=%b wdata=%h, expected 10 1 123456789abcdef0",
               obs_ready, obs_wm, obs_wd);
    end
    apply(2'b10, 2'b00, 9'd0, 9'd9, 64'd0, 64'd0, 1'b0);
    vectors++;
    if (obs_ready !== 2'b10 || obs_wm !== 1'b0) begin
      miscompares++;
      $display("FAIL single2: ready=%b wmode=%b, expected 10 0", obs_ready, obs_wm);
    end
    apply(2'b11, 2'b00, 9'd9, 9'd5, 64'd0, 64'd0, 1'b0);
    vectors++;
    if (obs_ready !== 2'b01 || obs_ready !== exp_g || obs_addr !== 9'd9) begin
      miscompares++;
      $display("FAIL single_then_both: ready=%b addr=%0d, expected 01 9", obs_ready, obs_addr);
    end
    apply(2'b00, 2'b00, '0, '0, '0, '0, 1'b0);
  endtask

  task automatic test_clear_inflight();
    apply(2'b01, 2'b00, 9'd5, 9'd0, 64'd0, 64'd0, 1'b0);
    vectors++;
    if (obs_ready !== 2'b01) begin
      miscompares++;
      $display("FAIL clear_read_grant: ready=%b, expected 01", obs_ready);
    end
    apply(2'b11, 2'b00, 9'd5, 9'd9, 64'd0, 64'd0, 1'b1);
    vectors++;
    if (obs_ready !== 2'b00 || obs_en !== 1'b0) begin
      miscompares++;
      $display("FAIL clear_cycle: ready=%b en=%b, expected 00 0", obs_ready, obs_en);
    end
    apply(2'b11, 2'b00, 9'd5, 9'd9, 64'd0, 64'd0, 1'b0);
    vectors++;
    if (obs_ready !== 2'b00 || obs_en !== 1'b0) begin
      miscompares++;
      $display("FAIL drain_cycle: ready=%b en=%b, expected 00 0", obs_ready, obs_en);
    end
    test_init_sequence();
    apply(2'b01, 2'b00, 9'd5, 9'd0, 64'd0, 64'd0, 1'b0);
    vectors++;
    if (obs_ready !== 2'b01 || obs_addr !== 9'd5) begin
      miscompares++;
      $display("FAIL post_clear_read: ready=%b addr=%0d, expected 01 5", obs_ready, obs_addr);
    end
    apply(2'b00, 2'b00, '0, '0, '0, '0, 1'b0);
  endtask

  task automatic test_reset_mid_init();
    apply(2'b00, 2'b00, '0, '0, '0, '0, 1'b1);
    apply(2'b00, 2'b00, '0, '0, '0, '0, 1'b0);
    for (int unsigned i = 0; i < 100; i++) begin
      apply(2'b00, 2'b00, '0, '0, '0, '0, 1'b0);
      vectors++;
      if (obs_en !== 1'b1 || obs_addr !== ADDR_W'(i)) begin
        miscompares++;
        $display("FAIL partial_init[%0d]: en=%b addr=%0d, expected 1 %0d", i, obs_en, obs_addr, i);
      end
    end
    reset = 1'b1;
    apply(2'b11, 2'b00, '0, '0, '0, '0, 1'b0);
    vectors++;
    if (obs_en !== 1'b0 || obs_ready !== 2'b00 || obs_done !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_init_reset: en=%b ready=%b init_done=%b, expected 0 00 0",
               obs_en, obs_ready, obs_done);
    end
    reset   = 1'b0;
    exp_ptr = 1'b0;
    test_init_sequence();
  endtask

  initial begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      macro_mem[i] = {$urandom(), $urandom()};
      shadow[i]    = '0;
    end
    bus.req_valid = 2'b00;
    bus.req_write = 2'b00;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    test_reset();
    test_raw();
    test_contention();
    test_single();
    test_clear_inflight();
    test_reset_mid_init();
    apply(2'b01, 2'b00, 9'd6, 9'd0, 64'd0, 64'd0, 1'b0);
    apply(2'b00, 2'b00, '0, '0, '0, '0, 1'b0);
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: %0d responses outstanding, expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sram_1rw_sched.md
# sram_1rw_sched

Scheduler for one single-port (1RW) OpenRAM macro of the `freepdk45_sram_1rw0r_*` family, for example the 512x64 data-way or 512x45 L2-TLB arrays. After reset, and whenever `clear` is asserted, it zero-fills the whole array. It then shares the one port between two valid/ready requesters with round-robin arbitration and returns read data one cycle after the grant. It sits between the cache/TLB control logic and the `*_ext` macro wrapper, and drives that wrapper's `RW0_*` pins.

## Interface
- `ADDR_W`, 9, address width
- `DATA_W`, 64, data width
- `DEPTH`, 512, number of entries; must satisfy `DEPTH` ≤ 2^`ADDR_W`
- `clock`  in  1  sole clock; also drives `RW0_clk` of the macro
- `reset`  in  1  synchronous, active-high
- `clear`  in  1  one-cycle pulse requesting a zero-fill of the full array
- `init_done`  out  1  high when the array is initialized and requests are accepted
- `req_valid[1:0]`  in  2  per-requester request valid
- `req_ready[1:0]`  out  2  per-requester grant; a transfer occurs when `valid & ready`
- `req_write[1:0]`  in  2  per-requester op: 1 = write, 0 = read
- `req_addr[i]`  in  `ADDR_W`  request address, one per requester
- `req_wdata[i]`  in  `DATA_W`  write data, one per requester
- `resp_valid[1:0]`  out  2  read data valid, to the requester that issued the read
- `resp_data`  out  `DATA_W`  read data, shared by both requesters
- `mem_en`  out  1  macro enable, maps to `RW0_en`
- `mem_wmode`  out  1  macro write mode, maps to `RW0_wmode`
- `mem_addr`  out  `ADDR_W`  maps to `RW0_addr`
- `mem_wdata`  out  `DATA_W`  maps to `RW0_wdata`
- `mem_rdata`  in  `DATA_W`  maps to `RW0_rdata`

## Operation
- **FSM states:** `INIT`, `RUN`, `DRAIN`.
- **Reset:** forces `INIT`, init counter = 0, RR pointer = 0, no read pending.
- **`INIT`:**
  - Each cycle: `mem_en`=1, `mem_wmode`=1, `mem_addr`=counter, `mem_wdata`=0; counter increments.
  - `req_ready`=0.
  - After writing address `DEPTH-1`: go to `RUN`, set `init_done`=1.
  - The counter is `ADDR_W+1` bits wide, so there is no wrap at `DEPTH`=2^`ADDR_W`.
- **`RUN`:** at most one grant per cycle.
  - Only one requester valid: it is granted.
  - Both valid: grant the requester selected by the RR pointer. After every grant, the pointer moves to the other requester. Idle cycles leave it unchanged.
  - `req_ready[i]` = the grant bit. It is combinational from `req_valid` and the pointer.
  - `req_ready` never depends on `req_write`, `req_addr` or `req_wdata`.
  - On a grant, drive `mem_en`=1, `mem_wmode`=`req_write[g]`, `mem_addr`, `mem_wdata` from the granted requester.
  - With no grant, `mem_en`=0.
- **Read return:** a granted read sets a pending flag and a requester id for the next cycle.
  - In that cycle: `resp_valid[id]`=1 and `resp_data`=`mem_rdata`.
  - Responses have no backpressure.
- **`clear` in `RUN`:** no grant in the `clear` cycle.
  - A read already pending returns normally in the next cycle.
  - Next state is `DRAIN` for 1 cycle, then `INIT` with counter = 0 and `init_done`=0.
- **`clear` in `INIT`:** restarts the counter at 0.
- **`clear` in `DRAIN`:** ignored.
- **Same-address traffic:** read-after-write to the same address in consecutive grants returns the new data. Write-first ordering is provided by the macro; no bypass logic is needed.

## Timing
- **Reset values:** `init_done`=0, `req_ready`=0, `resp_valid`=0, `mem_en`=0 in the reset cycle, `mem_wmode`=0, `resp_data` = `mem_rdata` passthrough.
- **Init duration:** `init_done` rises exactly `DEPTH` cycles after the first cycle with `reset` low.
- **Read latency:** grant in cycle N gives `resp_valid` in cycle N+1. Throughput is one operation per cycle.
- **Write:** committed at the clock edge that ends the grant cycle. No response is returned.
- **Reset during `INIT` or with a read pending:** discards all progress. No `resp_valid` is produced for the lost read.

## Structure
- **Shared package `sram_sched_pkg`:**
  - state enum (`INIT`, `RUN`, `DRAIN`)
  - requester-id type
  - request struct (write, addr, wdata)
- **Sub-module `rr_arb2`:** two-input round-robin arbiter with pointer register. Inputs: valid vector, `advance` enable. Outputs: one-hot grant.
- **Top level:** FSM, init counter, read-pending pipeline register and memory-port mux.

## Test plan
- **Reset/init:** release `reset` with `DEPTH`=512 → 512 consecutive writes of 0 to addresses 0..511; `init_done` high in cycle 512; `req_ready`=0 throughout.
- **Read-after-write:** req0 writes 0xDEAD_BEEF to address 5, then reads address 5 → `resp_valid[0]` one cycle after the read grant, `resp_data`=0xDEAD_BEEF; a read of address 6 returns 0.
- **Contention:** both requesters valid every cycle for 6 cycles → grants alternate 0,1,0,1,0,1; each read response goes to the correct `resp_valid` bit.
- **Single requester:** req1 alone valid for 3 cycles → granted every cycle; then both valid → req0 granted first (pointer advanced by the req1 grants).
- **Clear with read in flight:**
  - Inputs: read granted in cycle N, `clear` in N+1.
  - Expected: response in N+1, no grant in N+1, `DRAIN` in N+2, init writes from N+3, `init_done` low until they complete.
  - Check: a read of a previously written address afterwards returns 0.
- **Reset mid-init:** assert `reset` at counter = 100 → counter restarts at 0; the full 512-cycle init repeats.
